// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer driven by a 16x oversampled baud enable,
// with a one-byte receive buffer and rda / framing_err / overrun status flags.
module spart_rx #(
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OSR);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_A      = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] T_B      = TW'(OSR/2);
  localparam logic [TW-1:0] T_EVAL   = TW'(OSR/2 + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OSR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick, tick_nxt;
  logic [BW-1:0]        bitcnt, bitcnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sync1, rxs;
  logic                 samp_a, samp_b, maj;
  logic                 shift_en, load;

  assign maj  = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tick   <= '0;
      bitcnt <= '0;
    end else begin
      state  <= state_nxt;
      tick   <= tick_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick;
    bitcnt_nxt = bitcnt;
    shift_en   = 1'b0;
    load       = 1'b0;
    if (baud_en) begin
      tick_nxt = tick + TW'(1);
      unique case (state)
        IDLE: begin
          tick_nxt = '0;
          if (!rxs) state_nxt = START;
        end
        START: begin
          if (tick == T_EVAL && maj) begin
            state_nxt = IDLE;
            tick_nxt  = '0;
          end else if (tick == T_LAST) begin
            state_nxt  = DATA;
            bitcnt_nxt = '0;
          end
        end
        DATA: begin
          if (tick == T_EVAL) shift_en = 1'b1;
          if (tick == T_LAST) begin
            bitcnt_nxt = bitcnt + BW'(1);
            if (bitcnt == LAST_BIT) state_nxt = STOP;
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (tick == T_EVAL) begin
            load      = 1'b1;
            state_nxt = IDLE;
            tick_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
      shreg  <= '0;
    end else if (baud_en) begin
      if (tick == T_A) samp_a <= rxs;
      if (tick == T_B) samp_b <= rxs;
      if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
    end
  end

  // A new byte takes priority over a same-cycle read
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (load) begin
      rx_data     <= shreg;
      rda         <= 1'b1;
      framing_err <= ~maj;
      overrun     <= rda & ~rd;
    end else if (rd && rda) begin
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames are launched aligned to a baud tick so
// the load cycle of each byte is known exactly (620 clks after the aligning tick).
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst, baud_en, rxd, rd;
  logic [7:0] rx_data;
  logic       rda, framing_err, overrun, busy;

  int n_vec = 0;
  int n_err = 0;

  spart_rx #(.OSR(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .baud_en(baud_en), .rxd(rxd), .rd(rd),
    .rx_data(rx_data), .rda(rda), .framing_err(framing_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt     = 0;
    baud_en = 1'b0;
    forever begin
      @(negedge clk);
      baud_en = (cnt == 0);
      cnt     = (cnt + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic align_baud();
    do @(posedge clk); while (!baud_en);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    align_baud();
    @(negedge clk);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (64) @(negedge clk);
    end
    rxd = stop;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rd  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rda", rda, 1'b0);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset ferr", framing_err, 1'b0);
    chk("reset ovr", overrun, 1'b0);
    chk("reset busy", busy, 1'b0);

    // Plain byte then read
    send_frame(8'hA5, 1'b1);
    chk("a5 rda", rda, 1'b1);
    chk("a5 data", rx_data, 8'hA5);
    chk("a5 ferr", framing_err, 1'b0);
    chk("a5 ovr", overrun, 1'b0);
    chk("a5 busy", busy, 1'b0);
    rd_pulse();
    chk("a5 rd clears rda", rda, 1'b0);

    // Back-to-back bytes without a read
    send_frame(8'h3C, 1'b1);
    chk("3c rda", rda, 1'b1);
    chk("3c data", rx_data, 8'h3C);
    chk("3c ovr", overrun, 1'b0);
    send_frame(8'hC3, 1'b1);
    chk("c3 rda", rda, 1'b1);
    chk("c3 data", rx_data, 8'hC3);
    chk("c3 ovr", overrun, 1'b1);
    rd_pulse();
    chk("c3 rd rda", rda, 1'b0);
    chk("c3 rd ovr", overrun, 1'b0);
    chk("c3 rd ferr", framing_err, 1'b0);

    // Short glitch: false start
    align_baud();
    @(negedge clk);
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    chk("glitch busy high", busy, 1'b1);
    repeat (80) @(negedge clk);
    chk("glitch busy low", busy, 1'b0);
    chk("glitch rda", rda, 1'b0);

    // Stop bit low
    send_frame(8'h55, 1'b0);
    chk("55 rda", rda, 1'b1);
    chk("55 data", rx_data, 8'h55);
    chk("55 ferr", framing_err, 1'b1);
    repeat (64) @(negedge clk);
    chk("55 idle after false start", busy, 1'b0);
    chk("55 rda held", rda, 1'b1);
    rd_pulse();
    chk("55 rd ferr", framing_err, 1'b0);

    // Reset in the middle of data bit 4 of 0xFF
    align_baud();
    @(negedge clk);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    repeat (64 * 4 + 32) @(negedge clk);
    chk("ff busy before rst", busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst busy", busy, 1'b0);
    repeat (100) @(negedge clk);
    chk("rst no rda", rda, 1'b0);
    chk("rst data", rx_data, 8'h00);
    chk("rst busy idle", busy, 1'b0);
    send_frame(8'h81, 1'b1);
    chk("81 rda", rda, 1'b1);
    chk("81 data", rx_data, 8'h81);
    chk("81 ferr", framing_err, 1'b0);
    chk("81 ovr", overrun, 1'b0);

    // Read strobe coincides with the load of 0x7E (load at aligning tick + 620 clks)
    fork
      send_frame(8'h7E, 1'b1);
      begin
        align_baud();
        repeat (619) @(posedge clk);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    chk("7e rda", rda, 1'b1);
    chk("7e data", rx_data, 8'h7E);
    chk("7e ovr", overrun, 1'b0);
    chk("7e ferr", framing_err, 1'b0);
    rd_pulse();
    chk("7e rd rda", rda, 1'b0);
    rd_pulse();
    chk("rd with rda low", rda, 1'b0);
    chk("rd with rda low data", rx_data, 8'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- UART-style serial receiver for the SPART. Consumes the 16x-oversampled receive baud enable produced by the baud generator.
- Frame format is 8N1. Each byte is deserialized LSB first and held in a receive buffer with status flags for the bus-interface/CPU side.
- Sits between the external RX pin and the SPART register interface: the counterpart consumer of receive_baud.

Parameters:
- OSR, 16, baud_en ticks per bit period; must be a power of two, at least 8.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- baud_en  in  1  one-clk pulse per oversample tick (receive_baud).
- rxd  in  1  asynchronous serial input; idle high.
- rd  in  1  one-clk read strobe; consumes the buffered byte.
- rx_data  out  DATA_BITS  last received byte.
- rda  out  1  receive data available.
- framing_err  out  1  stop bit of the buffered byte sampled low.
- overrun  out  1  byte overwritten before it was read.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. All state is updated on posedge clk only.
- Reset values:
  - rx_data=0, rda=0, framing_err=0, overrun=0, busy=0.
  - FSM=IDLE, tick counter=0, bit counter=0.
  - Both synchronizer flops reset to 1.
  - Reset mid-frame abandons the frame; no flag is set.
- Input sync: rxd passes through a 2-flop synchronizer. Everything below uses the synchronized value rxs.
- Progress: the FSM, tick counter and samples advance only on cycles with baud_en=1. With baud_en held 0, all state holds.
- Tick counter: log2(OSR) bits, counting 0..OSR-1 and wrapping to 0. Cleared on entry to START.
- Majority sample: the bit value is the majority of rxs at ticks OSR/2-1, OSR/2 and OSR/2+1 (7, 8, 9 for OSR=16). Evaluated at tick OSR/2+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on baud_en with rxs=0, go to START with tick=0.
  - START: at tick 9, a majority of 1 means a false start; return to IDLE. Otherwise continue. At tick 15, go to DATA with bitcnt=0.
  - DATA: at tick 9, shift the majority into the MSB of a shift register (right shift, so LSB-first arrival). At tick 15, bitcnt increments. After bitcnt reaches DATA_BITS-1 at tick 15, go to STOP.
  - STOP: at tick 9, load rx_data from the shift register, set rda=1 and framing_err=~majority, then go to IDLE. The early return at mid-stop allows back-to-back frames.
- Latency: rda rises on the clock edge of the baud_en tick at stop-bit sample 9. rx_data is valid in the same cycle that rda reads 1.
- Read: when rd=1, on the next edge clear rda, framing_err and overrun. rd with rda=0 has no effect.
- New byte load while rda=1 and rd=0: rx_data is overwritten, overrun=1, and framing_err reflects the new byte.
- Simultaneous rd and new-byte load: the new byte wins. rda stays 1, overrun=0, and framing_err is taken from the new byte.
- Break condition (rxd held low): a frame of all-zero data is received with framing_err=1. IDLE then restarts on the still-low line, so frames repeat until rxd returns high.
- Glitch: a low pulse on rxd shorter than ~6 ticks that is seen only at the IDLE edge is rejected by the START majority check. busy falls when the FSM returns to IDLE.

Test Plan:
- Byte 0xA5, 8N1, baud_en every 4 clks (one bit = 64 clks) -> rda=1, rx_data=0xA5, framing_err=0, overrun=0, busy=0 after mid-stop. rd pulse -> rda=0 the next cycle.
- 0x3C followed back-to-back by 0xC3 with no read -> first rda=1 with 0x3C. Second byte gives rx_data=0xC3, overrun=1. rd -> all flags clear.
- rxd low for 3 baud ticks, then high -> FSM returns to IDLE after START tick 9. rda stays 0, busy pulses then 0.
- 0x55 sent with the stop bit driven low -> rda=1, rx_data=0x55, framing_err=1.
- rst asserted at DATA bit 4 of 0xFF, then a clean 0x81 sent -> no rda from the aborted frame. After the clean frame, rx_data=0x81, rda=1, flags 0.
- rd asserted in the same cycle that 0x7E lands while rda=1 -> rda=1, rx_data=0x7E, overrun=0.
